// File: rtl/fir_xifu_lsu_ctrl.sv
// ============================================================================
// Module   : fir_xifu_lsu_ctrl
// Brief    : Single-outstanding XIF load/store controller with commit tracking.
//            Optional WAIT_RESULT timeout enabled by FIR_XIFU_LSU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_xifu_lsu_ctrl #(
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,

    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ID_WIDTH-1:0] req_id_i,
    input  logic [31:0]         req_addr_i,
    input  logic [31:0]         req_wdata_i,

    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,

    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic                mem_we_o,
    output logic [ID_WIDTH-1:0] mem_id_o,
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_wdata_o,

    input  logic                mem_result_valid_i,
    input  logic [ID_WIDTH-1:0] mem_result_id_i,
    input  logic [31:0]         mem_result_rdata_i,
    input  logic                mem_result_err_i,

    output logic                rsp_valid_o,
    output logic [ID_WIDTH-1:0] rsp_id_o,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_err_o,

    output logic                stall_o,
    output logic                busy_o
);

    localparam int c_DEPTH = 2 ** ID_WIDTH;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_COMMIT = 2'd1,
        ISSUE       = 2'd2,
        WAIT_RESULT = 2'd3
    } state_t;

    generate
        if (ID_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("fir_xifu_lsu_ctrl: ID_WIDTH and TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    state_t                r_state;
    logic [c_DEPTH-1:0]    r_committed;
    logic [c_DEPTH-1:0]    w_committed_nxt;
    logic                  r_we;
    logic [ID_WIDTH-1:0]   r_id;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic                  r_killed;
    logic                  r_mem_valid;
    logic                  r_rsp_valid;
    logic [ID_WIDTH-1:0]   r_rsp_id;
    logic [31:0]           r_rsp_rdata;
    logic                  r_rsp_err;

    logic w_commit_hit;
    logic w_kill_hit;
    logic w_store_go;
    logic w_result_hit;
    logic w_timeout;

    assign w_commit_hit = commit_valid_i & ~commit_kill_i & (commit_id_i == r_id);
    assign w_kill_hit   = commit_valid_i &  commit_kill_i & (commit_id_i == r_id);
    assign w_store_go   = r_committed[req_id_i] |
                          (commit_valid_i & ~commit_kill_i & (commit_id_i == req_id_i));
    assign w_result_hit = mem_result_valid_i & (mem_result_id_i == r_id);

`ifdef FIR_XIFU_LSU_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0] r_tmo;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i || r_state != WAIT_RESULT) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_timeout = (r_state == WAIT_RESULT) &&
                       (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Completion clears the entry first so a same-cycle commit for that ID still lands.
    always_comb begin
        w_committed_nxt = r_committed;
        if (r_state == WAIT_RESULT && (w_result_hit || w_timeout)) begin
            w_committed_nxt[r_id] = 1'b0;
        end
        if (commit_valid_i) begin
            w_committed_nxt[commit_id_i] = ~commit_kill_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state     <= IDLE;
            r_committed <= '0;
            r_we        <= 1'b0;
            r_id        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_killed    <= 1'b0;
            r_mem_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_committed <= w_committed_nxt;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_we     <= req_we_i;
                        r_id     <= req_id_i;
                        r_addr   <= req_addr_i;
                        r_wdata  <= req_wdata_i;
                        r_killed <= 1'b0;
                        // Loads go out speculatively; stores wait for their commit.
                        if (!req_we_i || w_store_go) begin
                            r_state     <= ISSUE;
                            r_mem_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT_COMMIT;
                        end
                    end
                end
                WAIT_COMMIT: begin
                    if (w_kill_hit) begin
                        r_state <= IDLE;
                    end else if (w_commit_hit) begin
                        r_state     <= ISSUE;
                        r_mem_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mem_ready_i) begin
                        r_state     <= WAIT_RESULT;
                        r_mem_valid <= 1'b0;
                        if (w_kill_hit) begin
                            r_killed <= 1'b1;
                        end
                    end else if (w_kill_hit) begin
                        r_state     <= IDLE;
                        r_mem_valid <= 1'b0;
                    end
                end
                WAIT_RESULT: begin
                    if (w_kill_hit) begin
                        r_killed <= 1'b1;
                    end
                    if (w_result_hit || w_timeout) begin
                        r_state <= IDLE;
                        if (!r_killed && !w_kill_hit) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_id    <= r_id;
                            r_rsp_err   <= w_result_hit ? mem_result_err_i : 1'b1;
                            r_rsp_rdata <= (w_result_hit && !r_we) ? mem_result_rdata_i : 32'd0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE);
    assign stall_o     = req_valid_i & ~req_ready_o;
    assign mem_valid_o = r_mem_valid;
    assign mem_we_o    = r_we;
    assign mem_id_o    = r_id;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_id_o    = r_rsp_id;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_fir_xifu_lsu_ctrl.sv
// ============================================================================
// Module   : tb_fir_xifu_lsu_ctrl
// Brief    : Self-checking bench for fir_xifu_lsu_ctrl with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fir_xifu_lsu_ctrl;

    localparam int c_IDW = 4;
    localparam int c_TMO = 8;

    typedef struct packed {
        logic [c_IDW-1:0] id;
        logic [31:0]      rdata;
        logic             err;
    } rsp_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             clear_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_we_i;
    logic [c_IDW-1:0] req_id_i;
    logic [31:0]      req_addr_i;
    logic [31:0]      req_wdata_i;
    logic             commit_valid_i;
    logic [c_IDW-1:0] commit_id_i;
    logic             commit_kill_i;
    logic             mem_valid_o;
    logic             mem_ready_i;
    logic             mem_we_o;
    logic [c_IDW-1:0] mem_id_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic             mem_result_valid_i;
    logic [c_IDW-1:0] mem_result_id_i;
    logic [31:0]      mem_result_rdata_i;
    logic             mem_result_err_i;
    logic             rsp_valid_o;
    logic [c_IDW-1:0] rsp_id_o;
    logic [31:0]      rsp_rdata_o;
    logic             rsp_err_o;
    logic             stall_o;
    logic             busy_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    fir_xifu_lsu_ctrl #(
        .ID_WIDTH       (c_IDW),
        .TIMEOUT_CYCLES (c_TMO)
    ) u_dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .clear_i            (clear_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_we_i           (req_we_i),
        .req_id_i           (req_id_i),
        .req_addr_i         (req_addr_i),
        .req_wdata_i        (req_wdata_i),
        .commit_valid_i     (commit_valid_i),
        .commit_id_i        (commit_id_i),
        .commit_kill_i      (commit_kill_i),
        .mem_valid_o        (mem_valid_o),
        .mem_ready_i        (mem_ready_i),
        .mem_we_o           (mem_we_o),
        .mem_id_o           (mem_id_o),
        .mem_addr_o         (mem_addr_o),
        .mem_wdata_o        (mem_wdata_o),
        .mem_result_valid_i (mem_result_valid_i),
        .mem_result_id_i    (mem_result_id_i),
        .mem_result_rdata_i (mem_result_rdata_i),
        .mem_result_err_i   (mem_result_err_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_id_o           (rsp_id_o),
        .rsp_rdata_o        (rsp_rdata_o),
        .rsp_err_o          (rsp_err_o),
        .stall_o            (stall_o),
        .busy_o             (busy_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        req_valid_i        = 1'b0;
        req_we_i           = 1'b0;
        req_id_i           = '0;
        req_addr_i         = '0;
        req_wdata_i        = '0;
        commit_valid_i     = 1'b0;
        commit_id_i        = '0;
        commit_kill_i      = 1'b0;
        mem_ready_i        = 1'b0;
        mem_result_valid_i = 1'b0;
        mem_result_id_i    = '0;
        mem_result_rdata_i = '0;
        mem_result_err_i   = 1'b0;
    endtask

    task automatic drive_req(input logic we, input logic [c_IDW-1:0] id,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_id_i    = id;
        req_addr_i  = addr;
        req_wdata_i = wdata;
    endtask

    task automatic drive_commit(input logic [c_IDW-1:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    task automatic drive_result(input logic [c_IDW-1:0] id, input logic [31:0] rdata,
                                input logic err);
        mem_result_valid_i = 1'b1;
        mem_result_id_i    = id;
        mem_result_rdata_i = rdata;
        mem_result_err_i   = err;
    endtask

    task automatic push_exp(input logic [c_IDW-1:0] id, input logic [31:0] rdata,
                            input logic err);
        rsp_t e;
        e.id    = id;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    // Every response must match the oldest expected entry; any extra response is flagged.
    always @(negedge clk_i) begin
        if (rsp_valid_o) begin
            if (sb_q.size() == 0) begin
                check_eq("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check_eq("rsp_id",    64'(rsp_id_o),    64'(e.id));
                check_eq("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                check_eq("rsp_err",   64'(rsp_err_o),   64'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst_i   = 1'b1;
        clear_i = 1'b0;
        tick();
        tick();
        check_eq("rst_ready",     64'(req_ready_o), 64'd1);
        check_eq("rst_busy",      64'(busy_o),      64'd0);
        check_eq("rst_mem_valid", 64'(mem_valid_o), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        rst_i = 1'b0;
        tick();

        // Load id 3: accept 0, handshake 1, stray result 2, result 4, response 5
        drive_req(1'b0, 4'd3, 32'h0000_1000, 32'h0);
        check_eq("t1_ready", 64'(req_ready_o), 64'd1);
        check_eq("t1_stall", 64'(stall_o),     64'd0);
        tick();
        req_valid_i = 1'b0;
        check_eq("t1_mem_valid", 64'(mem_valid_o), 64'd1);
        check_eq("t1_mem_addr",  64'(mem_addr_o),  64'h1000);
        check_eq("t1_mem_id",    64'(mem_id_o),    64'd3);
        check_eq("t1_mem_we",    64'(mem_we_o),    64'd0);
        req_valid_i = 1'b1;
        check_eq("t1_stall_busy", 64'(stall_o), 64'd1);
        req_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        check_eq("t1_mem_valid_drop", 64'(mem_valid_o), 64'd0);
        drive_result(4'd7, 32'h0000_0BAD, 1'b0);
        tick();
        mem_result_valid_i = 1'b0;
        check_eq("t1_nonmatch_busy", 64'(busy_o), 64'd1);
        tick();
        drive_result(4'd3, 32'hCAFE_0001, 1'b0);
        push_exp(4'd3, 32'hCAFE_0001, 1'b0);
        tick();
        mem_result_valid_i = 1'b0;
        check_eq("t1_rsp_valid", 64'(rsp_valid_o), 64'd1);
        check_eq("t1_back_idle", 64'(req_ready_o), 64'd1);
        tick();
        check_eq("t1_rsp_pulse", 64'(rsp_valid_o), 64'd0);

        // Store id 5 waits for commit at cycle 3, issues at cycle 4
        drive_req(1'b1, 4'd5, 32'h0000_2000, 32'h1234_5678);
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_wait_busy",  64'(busy_o),      64'd1);
            check_eq("t2_wait_nomem", 64'(mem_valid_o), 64'd0);
            if (i == 2) drive_commit(4'd5, 1'b0);
            tick();
        end
        commit_valid_i = 1'b0;
        check_eq("t2_mem_valid", 64'(mem_valid_o), 64'd1);
        check_eq("t2_mem_we",    64'(mem_we_o),    64'd1);
        check_eq("t2_mem_wdata", 64'(mem_wdata_o), 64'h1234_5678);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        drive_result(4'd5, 32'hDEAD_BEEF, 1'b0);
        push_exp(4'd5, 32'h0, 1'b0);
        tick();
        mem_result_valid_i = 1'b0;
        check_eq("t2_rsp_valid", 64'(rsp_valid_o), 64'd1);
        tick();

        // Store id 2 killed while waiting for commit
        drive_req(1'b1, 4'd2, 32'h0000_3000, 32'h0);
        tick();
        req_valid_i = 1'b0;
        drive_commit(4'd2, 1'b1);
        tick();
        commit_valid_i = 1'b0;
        check_eq("t3_ready",     64'(req_ready_o), 64'd1);
        check_eq("t3_mem_valid", 64'(mem_valid_o), 64'd0);
        tick();
        check_eq("t3_no_rsp", 64'(rsp_valid_o), 64'd0);

        // Pre-committed store id 6 issues next cycle
        drive_commit(4'd6, 1'b0);
        tick();
        commit_valid_i = 1'b0;
        drive_req(1'b1, 4'd6, 32'h0000_4000, 32'hA5A5_A5A5);
        tick();
        req_valid_i = 1'b0;
        check_eq("t4_precommit_mem", 64'(mem_valid_o), 64'd1);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        drive_result(4'd6, 32'h0000_0055, 1'b1);
        push_exp(4'd6, 32'h0, 1'b1);
        tick();
        mem_result_valid_i = 1'b0;
        check_eq("t4_rsp_valid", 64'(rsp_valid_o), 64'd1);

        // Store id 9 with same-cycle commit; kill coincides with handshake
        drive_req(1'b1, 4'd9, 32'h0000_5000, 32'h0000_0009);
        drive_commit(4'd9, 1'b0);
        tick();
        req_valid_i    = 1'b0;
        commit_valid_i = 1'b0;
        check_eq("t5_samecycle_mem", 64'(mem_valid_o), 64'd1);
        mem_ready_i = 1'b1;
        drive_commit(4'd9, 1'b1);
        tick();
        mem_ready_i    = 1'b0;
        commit_valid_i = 1'b0;
        check_eq("t5_killed_busy", 64'(busy_o), 64'd1);
        drive_result(4'd9, 32'h0, 1'b0);
        tick();
        mem_result_valid_i = 1'b0;
        check_eq("t5_killed_norsp", 64'(rsp_valid_o), 64'd0);
        check_eq("t5_killed_idle",  64'(busy_o),      64'd0);

        // Load id 1 stalled 5 cycles, then killed in WAIT_RESULT
        drive_req(1'b0, 4'd1, 32'h0000_6000, 32'h0);
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("t6_hold_valid", 64'(mem_valid_o), 64'd1);
            check_eq("t6_hold_addr",  64'(mem_addr_o),  64'h6000);
            tick();
        end
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        drive_commit(4'd1, 1'b1);
        tick();
        commit_valid_i = 1'b0;
        drive_result(4'd1, 32'h1111_1111, 1'b0);
        tick();
        mem_result_valid_i = 1'b0;
        check_eq("t6_norsp", 64'(rsp_valid_o), 64'd0);
        check_eq("t6_idle",  64'(busy_o),      64'd0);

        // Kill in ISSUE before handshake drops the request
        drive_req(1'b0, 4'd4, 32'h0000_7000, 32'h0);
        tick();
        req_valid_i = 1'b0;
        drive_commit(4'd4, 1'b1);
        tick();
        commit_valid_i = 1'b0;
        check_eq("t7_mem_drop", 64'(mem_valid_o), 64'd0);
        check_eq("t7_ready",    64'(req_ready_o), 64'd1);
        tick();
        check_eq("t7_no_rsp", 64'(rsp_valid_o), 64'd0);

        // Request held across completion is accepted only the cycle after
        drive_req(1'b0, 4'd8, 32'h0000_8000, 32'h0);
        tick();
        mem_ready_i = 1'b1;
        drive_req(1'b0, 4'd13, 32'h0000_8800, 32'h0);
        tick();
        mem_ready_i = 1'b0;
        check_eq("t8_stall", 64'(stall_o), 64'd1);
        drive_result(4'd8, 32'h8888_0008, 1'b0);
        push_exp(4'd8, 32'h8888_0008, 1'b0);
        tick();
        mem_result_valid_i = 1'b0;
        check_eq("t8_not_accepted", 64'(mem_valid_o), 64'd0);
        check_eq("t8_ready",        64'(req_ready_o), 64'd1);
        tick();
        req_valid_i = 1'b0;
        check_eq("t8_second_mem", 64'(mem_valid_o), 64'd1);
        check_eq("t8_second_id",  64'(mem_id_o),    64'd13);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        drive_result(4'd13, 32'h1313_1313, 1'b0);
        push_exp(4'd13, 32'h1313_1313, 1'b0);
        tick();
        mem_result_valid_i = 1'b0;
        tick();

`ifdef FIR_XIFU_LSU_TIMEOUT_EN
        // No result: error response exactly TIMEOUT_CYCLES after entering WAIT_RESULT
        drive_req(1'b0, 4'd12, 32'h0000_9000, 32'h0);
        tick();
        req_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        for (int k = 0; k < c_TMO; k++) begin
            check_eq("t9_tmo_early", 64'(rsp_valid_o), 64'd0);
            if (k == c_TMO - 1) push_exp(4'd12, 32'h0, 1'b1);
            tick();
        end
        check_eq("t9_tmo_rsp",  64'(rsp_valid_o), 64'd1);
        check_eq("t9_tmo_idle", 64'(busy_o),      64'd0);
        tick();
`else
        // Without timeout the block keeps waiting well past TIMEOUT_CYCLES
        drive_req(1'b0, 4'd12, 32'h0000_9000, 32'h0);
        tick();
        req_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        repeat (3 * c_TMO) tick();
        check_eq("t9_still_busy", 64'(busy_o),      64'd1);
        check_eq("t9_no_rsp",     64'(rsp_valid_o), 64'd0);
        drive_result(4'd12, 32'h1212_1212, 1'b0);
        push_exp(4'd12, 32'h1212_1212, 1'b0);
        tick();
        mem_result_valid_i = 1'b0;
        check_eq("t9_late_rsp", 64'(rsp_valid_o), 64'd1);
        tick();
`endif

        // Reset in WAIT_RESULT, then a stale result
        drive_req(1'b0, 4'd10, 32'h0000_A000, 32'h0);
        tick();
        req_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_eq("t10_ready",     64'(req_ready_o), 64'd1);
        check_eq("t10_busy",      64'(busy_o),      64'd0);
        check_eq("t10_stall",     64'(stall_o),     64'd0);
        check_eq("t10_mem_valid", 64'(mem_valid_o), 64'd0);
        check_eq("t10_mem_we",    64'(mem_we_o),    64'd0);
        check_eq("t10_mem_id",    64'(mem_id_o),    64'd0);
        check_eq("t10_mem_addr",  64'(mem_addr_o),  64'd0);
        check_eq("t10_mem_wdata", 64'(mem_wdata_o), 64'd0);
        check_eq("t10_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("t10_rsp_id",    64'(rsp_id_o),    64'd0);
        check_eq("t10_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        check_eq("t10_rsp_err",   64'(rsp_err_o),   64'd0);
        drive_result(4'd10, 32'hBADD_CAFE, 1'b0);
        tick();
        mem_result_valid_i = 1'b0;
        check_eq("t10_stale_norsp", 64'(rsp_valid_o), 64'd0);
        check_eq("t10_stale_idle",  64'(busy_o),      64'd0);

        // clear_i wipes the commit table: committed id 11 must wait again
        drive_commit(4'd11, 1'b0);
        tick();
        commit_valid_i = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        drive_req(1'b1, 4'd11, 32'h0000_B000, 32'h0000_000B);
        tick();
        req_valid_i = 1'b0;
        check_eq("t11_wait_commit", 64'(busy_o),      64'd1);
        check_eq("t11_no_mem",      64'(mem_valid_o), 64'd0);
        drive_commit(4'd11, 1'b1);
        tick();
        commit_valid_i = 1'b0;
        check_eq("t11_killed_idle", 64'(busy_o), 64'd0);
        tick();
        tick();

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
